// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants, types and helpers for the programmable
//               clock divider and its per-channel sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  // Smallest divisor that still yields a toggling output; smaller writes clamp here.
  localparam int MIN_DIV = 2;

  // What a channel does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_IDLE    = 2'd0,  // channel disabled: held at count 0, output low
    ACT_RESTART = 2'd1,  // first enabled cycle or sync: count restarts at 0, no tick
    ACT_WRAP    = 2'd2,  // last count of the period: wrap to 0 and tick
    ACT_COUNT   = 2'd3   // ordinary increment
  } chan_act_e;

  // Width of the channel-select bus; at least one bit even for a single channel.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_channel.sv
`default_nettype none
// ============================================================================
// Module      : divider_channel
// Description : One independent divider channel: active/shadow divisor,
//               period counter, registered divided clock, tick and pending.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             i_enable,
  input  logic             i_sync,
  input  logic             i_load,     // already decoded for this channel
  input  logic [WIDTH-1:0] i_div,
  output logic             o_out_clk,
  output logic             o_tick,
  output logic             o_pending
);

  localparam logic [WIDTH-1:0] C_MIN_DIV = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] C_DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_cnt;
  logic             r_pend;
  logic             r_run;      // enable as seen on the previous edge
  logic             r_out;
  logic             r_tick;

  chan_act_e        w_act;
  logic [WIDTH-1:0] w_div_clamped;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_half_nxt;
  logic             w_pend_nxt;
  logic             w_tick_nxt;
  logic             w_out_nxt;

  assign w_div_clamped = (i_div < C_MIN_DIV) ? C_MIN_DIV : i_div;

  // Decide the action for the coming edge; sync outranks a coincident wrap.
  always_comb begin
    w_act = ACT_IDLE;
    if (!i_enable) begin
      w_act = ACT_IDLE;
    end else if (!r_run || i_sync) begin
      w_act = ACT_RESTART;
    end else if (r_cnt == r_div - WIDTH'(1)) begin
      w_act = ACT_WRAP;
    end else begin
      w_act = ACT_COUNT;
    end
  end

  // Next-state values; a load to a running channel always lands in the shadow,
  // even on a wrap edge, so the period just starting keeps the old divisor.
  always_comb begin
    w_cnt_nxt    = '0;
    w_div_nxt    = r_div;
    w_shadow_nxt = r_shadow;
    w_pend_nxt   = r_pend;
    w_tick_nxt   = 1'b0;
    case (w_act)
      ACT_IDLE: begin
        if (i_load) begin
          w_div_nxt  = w_div_clamped;
          w_pend_nxt = 1'b0;
        end
      end
      ACT_RESTART: begin
        if (i_sync && r_pend) begin
          w_div_nxt  = r_shadow;
          w_pend_nxt = 1'b0;
        end
      end
      ACT_WRAP: begin
        w_tick_nxt = 1'b1;
        if (r_pend) begin
          w_div_nxt  = r_shadow;
          w_pend_nxt = 1'b0;
        end
      end
      ACT_COUNT: begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    endcase
    if (i_enable && i_load) begin
      w_shadow_nxt = w_div_clamped;
      w_pend_nxt   = 1'b1;
    end
  end

  // High phase is the ceiling half so odd divisors spend the extra cycle high.
  assign w_half_nxt = w_div_nxt - (w_div_nxt >> 1);
  assign w_out_nxt  = i_enable && (w_cnt_nxt < w_half_nxt);

  // Channel state registers; reset discards any period in progress and pending load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div    <= C_DEF_DIV;
      r_shadow <= C_DEF_DIV;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_run    <= 1'b0;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_shadow <= w_shadow_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_run    <= i_enable;
      r_out    <= w_out_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign o_out_clk = r_out;
  assign o_tick    = r_tick;
  assign o_pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/programmable_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : programmable_clock_divider
// Description : NUM_CH independent programmable clock dividers sharing one
//               load bus and a common phase-sync strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module programmable_clock_divider
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int WIDTH       = 16,
  parameter  int DEFAULT_DIV = 4,
  localparam int SEL_W       = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic [NUM_CH-1:0] enable,
  input  logic              load,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [WIDTH-1:0]  div_value,
  input  logic              sync,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] w_load_vec;

  // Per-channel load decode and channel instances; select codes at or above
  // NUM_CH match no channel, so such loads are simply dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_load_vec[i] = load && (ch_sel == SEL_W'(i));

    divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_enable  (enable[i]),
      .i_sync    (sync),
      .i_load    (w_load_vec[i]),
      .i_div     (div_value),
      .o_out_clk (out_clk[i]),
      .o_tick    (tick[i]),
      .o_pending (pending[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_programmable_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_programmable_clock_divider
// Description : Directed scenarios followed by random traffic, each cycle
//               compared against a period/phase reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_programmable_clock_divider;

  // Five channels so that the 3-bit select has spare codes (5..7) and an
  // out-of-range load such as ch_sel=5 can actually be driven.
  localparam int NUM_CH = 5;
  localparam int WIDTH  = 16;
  localparam int DEF    = 4;
  localparam int SW     = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] enable = '0;
  logic              load = 1'b0;
  logic [SW-1:0]     ch_sel = '0;
  logic [WIDTH-1:0]  div_value = '0;
  logic              sync = 1'b0;
  logic [NUM_CH-1:0] out_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  programmable_clock_divider #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .ch_sel    (ch_sel),
    .div_value (div_value),
    .sync      (sync),
    .out_clk   (out_clk),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Reference model: per channel a divisor, shadow, pending flag and the
  // position within the current period (-1 while the channel is stopped).
  int m_d  [NUM_CH];
  int m_sh [NUM_CH];
  int m_ph [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_tick [NUM_CH];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_d[c] = DEF; m_sh[c] = DEF; m_ph[c] = -1; m_pend[c] = 0; m_tick[c] = 0;
    end
  endfunction

  function automatic void model_step(logic [NUM_CH-1:0] en, bit ld, int sel, int val, bit sy);
    int v = (val < 2) ? 2 : val;
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit = ld && (sel == c);
      m_tick[c] = 0;
      if (!en[c]) begin
        m_ph[c] = -1;
        if (hit) begin m_d[c] = v; m_pend[c] = 0; end
      end else begin
        if (m_ph[c] < 0 || sy) begin
          m_ph[c] = 0;
          if (sy && m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
        end else if (m_ph[c] == m_d[c] - 1) begin
          m_ph[c] = 0;
          m_tick[c] = 1;
          if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
        end else begin
          m_ph[c] = m_ph[c] + 1;
        end
        if (hit) begin m_sh[c] = v; m_pend[c] = 1; end
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] exp_out();
    logic [NUM_CH-1:0] e = '0;
    for (int c = 0; c < NUM_CH; c++)
      e[c] = (m_ph[c] >= 0) && (m_ph[c] < m_d[c] - m_d[c] / 2);
    return e;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] e = '0;
    for (int c = 0; c < NUM_CH; c++) e[c] = m_tick[c];
    return e;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_pend();
    logic [NUM_CH-1:0] e = '0;
    for (int c = 0; c < NUM_CH; c++) e[c] = m_pend[c];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_clk"}, out_clk, exp_out());
    chk({tag, ".tick"},    tick,    exp_tick());
    chk({tag, ".pending"}, pending, exp_pend());
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic cyc(input string tag, input logic [NUM_CH-1:0] en,
                     input bit ld = 0, input int sel = 0, input int val = 0, input bit sy = 0);
    enable    = en;
    load      = ld;
    ch_sel    = SW'(sel);
    div_value = WIDTH'(val);
    sync      = sy;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step(en, ld, sel, val, sy);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input logic [NUM_CH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cyc(tag, en);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [NUM_CH-1:0] r_en;
    bit found;

    // Asynchronous reset before any clock edge.
    model_reset();
    #2 reset = 1'b0;
    #1;
    check_all("reset_async");
    run("reset_hold", '0, 2);
    reset = 1'b1;

    // All channels at the default divisor of 4.
    run("default_div4", '1, 14);

    // Channel 1: mid-period load of 7, pending until the wrap.
    run("pre_load7", '1, 1);
    cyc("load7_ch1", '1, 1, 1, 7);
    run("div7_ch1", '1, 22);

    // Channel 2 disabled, load 1 (clamps to 2), then enable.
    run("ch2_off", 5'b11011, 3);
    cyc("load1_ch2_off", 5'b11011, 1, 2, 1);
    run("ch2_still_off", 5'b11011, 2);
    run("ch2_div2", '1, 8);

    // Channel 0 to 5, channel 3 to 3, free-run, then sync.
    cyc("load5_ch0", '1, 1, 0, 5);
    cyc("load3_ch3", '1, 1, 3, 3);
    run("free_run", '1, 13);
    cyc("sync", '1, 0, 0, 0, 1);
    run("post_sync", '1, 16);

    // Load coincident with channel 1's wrap keeps the old divisor one period.
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_ph[1] == m_d[1] - 1) found = 1;
      else cyc("seek_wrap", '1);
    end
    n_chk++;
    assert (found) else begin
      n_fail++;
      $error("FAIL seek_wrap_bound: observed %0d expected %0d", found, 1);
    end
    cyc("load9_at_wrap", '1, 1, 1, 9);
    run("after_wrap_load", '1, 20);

    // Out-of-range select: no channel may change.
    cyc("load_sel5", '1, 1, 5, 2);
    cyc("load_sel7", '1, 1, 7, 3);
    run("after_oob", '1, 12);

    // Reset mid-period with a pending load.
    cyc("load11_ch0", '1, 1, 0, 11);
    run("pending_hold", '1, 2);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_all("reset_mid");
    run("reset_mid_hold", '1, 2);
    reset = 1'b1;
    run("after_reset", '1, 12);

    // Random traffic.
    r_en = '1;
    for (int k = 0; k < 450; k++) begin
      bit ld, sy;
      int sel, val;
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 15) == 0) r_en[c] = ~r_en[c];
      ld  = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 7);
      val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 12);
      sy  = ($urandom_range(0, 24) == 0);
      cyc("random", r_en, ld, sel, val, sy);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
